// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the RAM port arbiter.
// State encoding, RAM direction codes and default geometry.
package ram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_DRAIN
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int DEF_AW = 5;
  localparam int DEF_DW = 32;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
// The pointer moves only when a grant is issued.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  // ptr=1 gives requester 1 priority on a tie
  logic ptr;

  always_comb begin
    gnt    = 2'b00;
    gnt[0] = en & req[0] & (~req[1] | ~ptr);
    gnt[1] = en & req[1] & (~req[0] | ptr);
  end

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= 1'b0;
    else if (|gnt)
      ptr <= gnt[0];
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-requester single-port RAM arbiter with
// initialisation sweep and drain-before-clear.
module ram_port_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  output logic          init_done,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_cs,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  state_t        state, state_n;
  logic [AW-1:0] cnt;
  logic [1:0]    gnt;
  logic          arb_en;
  logic          sel_we;
  logic          cs_q, rw_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          t1v, t1id, t2v, t2id;

  assign arb_en = (state == ST_RUN) & ~clr & ~rst;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({req1, req0}),
    .en  (arb_en),
    .gnt (gnt)
  );

  assign gnt0   = gnt[0];
  assign gnt1   = gnt[1];
  assign sel_we = gnt[1] ? we1 : we0;

  always_comb begin
    state_n = state;
    unique case (state)
      ST_INIT:  if (!clr && cnt == '1) state_n = ST_RUN;
      ST_RUN:   if (clr) state_n = ST_DRAIN;
      ST_DRAIN: if (!t1v && !t2v) state_n = ST_INIT;
      default:  state_n = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_n;
      // counter idles at zero outside INIT so re-entry starts at 0
      if (state != ST_INIT || clr)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q    <= 1'b0;
      rw_q    <= RW_READ;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      cs_q <= |gnt;
      if (|gnt) begin
        rw_q    <= sel_we ? RW_WRITE : RW_READ;
        addr_q  <= gnt[1] ? addr1 : addr0;
        wdata_q <= gnt[1] ? wdata1 : wdata0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t1v  <= 1'b0;
      t1id <= 1'b0;
      t2v  <= 1'b0;
      t2id <= 1'b0;
    end else begin
      t1v  <= (|gnt) & ~sel_we;
      t1id <= gnt[1];
      t2v  <= t1v;
      t2id <= t1id;
    end
  end

  always_comb begin
    mem_cs    = cs_q;
    mem_rw    = rw_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if (rst) begin
      mem_cs    = 1'b0;
      mem_rw    = RW_READ;
      mem_addr  = '0;
      mem_wdata = '0;
    end else if (state == ST_INIT) begin
      mem_cs    = 1'b1;
      mem_rw    = RW_WRITE;
      mem_addr  = cnt;
      mem_wdata = INIT_VAL;
    end
  end

  assign init_done = (state == ST_RUN) & ~rst;
  assign rvalid0   = t2v & ~t2id & ~rst;
  assign rvalid1   = t2v & t2id & ~rst;
  assign rdata0    = mem_rdata;
  assign rdata1    = mem_rdata;

endmodule
